sinc3_ctrl: RTL

Sequencing controller for the sinc3 decimation filter. It configures the filter's decimation mode, holds the filter in reset while idle, discards the settling words after every (re)start, and delivers valid 16-bit conversion words to downstream logic through a 2-entry valid/ready buffer with overrun detection. It runs on the modulator clock and sits between the filter and the word consumer (register file / DMA).

---
 rtl/sinc3_pkg.sv | 26 ++
 rtl/sinc3_word_fifo.sv | 61 ++++++
 rtl/sinc3_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/sinc3_pkg.sv
// Shared types and constants for the sinc3 decimation filter controller.
package sinc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST,
    ST_SETTLE,
    ST_RUN
  } state_t;

  localparam logic [1:0] MODE4 = 2'b00;
  localparam logic [1:0] MODE2 = 2'b01;
  localparam logic [1:0] MODE1 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DECIM_SHORT = 256;
  localparam int DECIM_LONG  = 4096;

  localparam int WORD_W = 16;

  // Word period in mclk1 cycles selected by the upper mode bit.
  function automatic int decim_len(input logic [1:0] mode);
    return mode[1] ? DECIM_LONG : DECIM_SHORT;
  endfunction

endpackage

// File: rtl/sinc3_word_fifo.sv
// Two-entry word FIFO; head register drives the consumer directly.
module sinc3_word_fifo
  import sinc3_pkg::*;
(
  input  logic              mclk1,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] head_q;
  logic [WORD_W-1:0] tail_q;
  logic [1:0]        count_q;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer still lands when the head leaves in the same cycle.
  assign do_pop  = pop & (count_q != 2'd0);
  assign do_push = push & ((count_q != 2'd2) | do_pop);

  always_ff @(posedge mclk1) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= wdata;
          else                 tail_q <= wdata;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= wdata;
          end else begin
            head_q <= tail_q;
            tail_q <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata = head_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/sinc3_ctrl.sv
// Sequencer for the sinc3 filter: mode setup, reset hold, settling discard and
// delivery of conversion words through a small valid/ready buffer.
module sinc3_ctrl
  import sinc3_pkg::*;
#(
  parameter int SETTLE_WORDS = 3,
  parameter int RST_CYCLES   = 4
) (
  input  logic              mclk1,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode_req,
  output logic [1:0]        filt_mode,
  output logic              filt_reset,
  input  logic              filt_word_clk,
  input  logic [WORD_W-1:0] filt_data,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       word_cnt
);

  localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_WORDS - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] rst_cnt_q;
  logic [7:0] settle_cnt_q;
  logic       wclk_q;
  logic       cap_q;
  logic       word_edge;
  logic       start_ok;
  logic       push;
  logic       push_ok;
  logic       fifo_full;
  logic       fifo_empty;

  assign start_ok  = start & ~stop & (state_q == ST_IDLE);
  assign word_edge = filt_word_clk & ~wclk_q & ~filt_reset;
  assign push      = cap_q & (state_q == ST_RUN) & ~stop;
  assign push_ok   = push & (~fifo_full | (out_ready & ~fifo_empty));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_RST;
      ST_RST:    if (rst_cnt_q == RST_LAST) state_d = ST_SETTLE;
      ST_SETTLE: if (cap_q && settle_cnt_q == SETTLE_LAST) state_d = ST_RUN;
      ST_RUN:    state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
    if (stop) state_d = ST_IDLE;
  end

  always_ff @(posedge mclk1) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      filt_reset   <= 1'b1;
      filt_mode    <= MODE4;
      rst_cnt_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      filt_reset <= (state_d == ST_IDLE) || (state_d == ST_RST);
      if (start_ok) filt_mode <= mode_req;
      rst_cnt_q <= (state_q == ST_RST) ? rst_cnt_q + 8'd1 : 8'd0;
      if (start_ok)                              settle_cnt_q <= '0;
      else if (state_q == ST_SETTLE && cap_q)    settle_cnt_q <= settle_cnt_q + 8'd1;
    end
  end

  // The capture strobe lags the word clock edge by a cycle so filt_data has settled.
  always_ff @(posedge mclk1) begin
    if (reset) begin
      wclk_q <= 1'b0;
      cap_q  <= 1'b0;
    end else begin
      wclk_q <= filt_word_clk;
      cap_q  <= word_edge;
    end
  end

  always_ff @(posedge mclk1) begin
    if (reset) begin
      overrun  <= 1'b0;
      word_cnt <= '0;
    end else if (start_ok) begin
      overrun  <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (push && !push_ok) overrun <= 1'b1;
      if (push_ok && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
    end
  end

  sinc3_word_fifo u_fifo (
    .mclk1 (mclk1),
    .reset (reset),
    .flush (start_ok | stop),
    .push  (push),
    .pop   (out_ready),
    .wdata (filt_data),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign busy      = (state_q != ST_IDLE);

endmodule
